// File: rtl/window_5x5_gen.sv
// 5x5 sliding-window generator over a raster pixel stream, built on 4 cascaded line buffers.
// Optional macro FRAME_DONE_EN adds a frame_done pulse alongside the last window of each frame.
module window_5x5_gen #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sof,
  input  logic         pix_valid,
  input  logic [11:0]  pix_in,
  output logic         start,
  output logic [299:0] win_out
`ifdef FRAME_DONE_EN
  ,
  output logic         frame_done
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(4);
  localparam logic [RW-1:0] ROW_MIN  = RW'(4);

  logic [CW-1:0] col;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] row;
  logic [RW-1:0] eff_row;
  logic          win_ok;

  logic [11:0] lb  [4][IMG_W];
  logic [11:0] rd  [4];
  logic [11:0] win [5][5];

  // sof forces the current pixel to (0,0) regardless of where the counters are
  assign eff_col = sof ? '0 : col;
  assign eff_row = sof ? '0 : row;
  assign win_ok  = (eff_row >= ROW_MIN) && (eff_col >= COL_MIN);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd[k] = lb[k][eff_col];
    end
  end

  // line buffer RAM is intentionally not reset; row gating keeps stale data hidden
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb[0][eff_col] <= pix_in;
      for (int k = 1; k < 4; k++) begin
        lb[k][eff_col] <= rd[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col   <= '0;
      row   <= '0;
      start <= 1'b0;
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      start <= pix_valid && win_ok;
      if (pix_valid) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            win[r][c] <= win[r][c+1];
          end
        end
        win[0][4] <= rd[3];
        win[1][4] <= rd[2];
        win[2][4] <= rd[1];
        win[3][4] <= rd[0];
        win[4][4] <= pix_in;
        if (eff_col == COL_LAST) begin
          col <= '0;
          row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
        end else begin
          col <= eff_col + CW'(1);
          row <= eff_row;
        end
      end
    end
  end

`ifdef FRAME_DONE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= pix_valid && (eff_row == ROW_LAST) && (eff_col == COL_LAST);
    end
  end
`endif

  always_comb begin
    win_out = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        win_out[(r*5+c)*12 +: 12] = win[r][c];
      end
    end
  end

endmodule

// File: doc/window_5x5_gen.md
WINDOW_5X5_GEN -- requirements
Module: window_5x5_gen

Interface
REQ-001 Parameter IMG_W, default 16: active pixels per line; legal range 5 to 4096.
REQ-002 Parameter IMG_H, default 16: lines per frame; legal range 5 to 4096.
REQ-003 Port clk, input, 1: single clock; all state on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-low reset.
REQ-005 Port sof, input, 1: start of frame; qualified by pix_valid.
REQ-006 Port pix_valid, input, 1: pix_in is accepted this cycle.
REQ-007 Port pix_in, input, 12: raster-order pixel.
REQ-008 Port start, output, 1: one-cycle pulse; win_out holds a complete 5x5 window.
REQ-009 Port win_out, output, 300: window packing.
- Tap (r,c) is bits [(r*5+c)*12 +: 12], with r and c in 0..4.
- r=0 is the oldest row (-2); c=0 is the oldest column (-2).
- Tap (2,2) is the centre pixel.
REQ-010 Port frame_done, output, 1: present only when FRAME_DONE_EN is defined.

Function
REQ-011 The block SHALL hold 4 line buffers of IMG_W x 12 bits, cascaded.
- On an accepted pixel at column col, it reads all buffers at col before writing.
- It writes pix_in into buffer 0 and the old buffer k value into buffer k+1.
REQ-012 On each accepted pixel, every window row SHALL shift one column toward c=0.
- Column c=4 loads buffer 3, buffer 2, buffer 1, buffer 0 and pix_in, for rows 0 to 4 respectively.
REQ-013 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance only on accepted pixels.
- col wraps to 0 after IMG_W-1, and row then increments.
- row wraps to 0 after the pixel at (IMG_H-1, IMG_W-1).
REQ-014 An accepted pixel with sof=1 SHALL be treated as position (0,0), regardless of the counters.
REQ-015 start SHALL assert one cycle after accepting the pixel at (row,col) when row>=4 and col>=4.
- The window centre is then (row-2, col-2).
- start is 0 in every other cycle.
REQ-016 Windows SHALL never straddle lines or frames.
- This is guaranteed by the col>=4 and row>=4 gating.
- Buffer contents from a previous frame or from before reset are never exposed.
REQ-017 When pix_valid=0, the window registers, counters and line buffers SHALL hold, and start SHALL be 0.
REQ-018 There is no backpressure; the block SHALL accept one pixel every cycle indefinitely.
REQ-019 Pixel values SHALL pass through bit-exact, with no arithmetic or truncation; 4095 passes as 4095.
REQ-020 Latency from the accepted pixel to start and win_out update SHALL be exactly 1 cycle.

Reset
REQ-021 While rst=0, outputs SHALL be: start=0, win_out=0, frame_done=0.
- Counters and window registers clear to 0.
- Line buffer RAM is not cleared.
REQ-022 Reset mid-frame SHALL abandon the frame.
- The first pixel after reset release is treated as (0,0), whether or not sof is asserted.
- No start is issued until 4 further lines plus 5 pixels have been accepted.

Configuration
REQ-023 Macro FRAME_DONE_EN.
- When defined: frame_done pulses for one cycle, one cycle after the pixel at (IMG_H-1, IMG_W-1) is accepted, coincident with the last start of the frame.
- When undefined: the frame_done port and its logic are absent, and all other behaviour is identical.

Verification
Common setup for all scenarios: IMG_W=8, IMG_H=8, pixel value = row*16+col.
REQ-024 Assert rst=0 mid-stream -> start=0, win_out=0 immediately; after release, the next start occurs exactly 37 accepted pixels later.
REQ-025 Feed a continuous frame -> first start one cycle after the 37th pixel.
- tap(0,0)=0, tap(2,2)=34, tap(4,4)=68, tap(0,4)=4.
REQ-026 Feed a full frame -> exactly 16 start pulses.
- The last pulse has tap(2,2)=5*16+5=85 and tap(4,4)=119.
REQ-027 Insert 3 idle cycles (pix_valid=0) between every pixel -> the window sequence is identical to REQ-025/026, and start is never high during idle cycles.
REQ-028 Assert sof with pixel 20, then continue -> the first start comes 37 pixels after that sof pixel, with centre equal to the value fed at sof+18.
REQ-029 With FRAME_DONE_EN defined -> frame_done=1 only in the cycle of the 16th start. Without the macro, REQ-024 to REQ-028 give unchanged results.
